rsa_mont_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Montgomery multiplier between several requesters inside the RSA decryption datapath. Each requester posts an operand pair. The arbiter grants one request at a time, starts the multiplier, waits for its finish strobe, and returns the product to the winning requester with a one-cycle done pulse. This lets the exponentiation controller issue its two per-bit products (m·t and t·t) to a single multiplier instance instead of two.

---
 rtl/rsa_mont_arbiter.sv | 127 ++++++++++++
 tb/tb_rsa_mont_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_mont_arbiter.sv
// Round-robin arbiter that time-shares one Montgomery multiplier between N_REQ requesters.
// Grants one operand pair per job, waits for the multiplier finish and returns the product.
module rsa_mont_arbiter #(
  parameter int unsigned W     = 256,
  parameter int unsigned N_REQ = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_a,
  input  logic [N_REQ*W-1:0] i_b,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic [W-1:0]       o_result,
  output logic               o_busy,
  output logic               o_mont_start,
  output logic [W-1:0]       o_mont_a,
  output logic [W-1:0]       o_mont_b,
  input  logic [W-1:0]       i_mont_result,
  input  logic               i_mont_finish
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [W-1:0]     result_q, result_d;
  logic [W-1:0]     mont_a_q, mont_a_d;
  logic [W-1:0]     mont_b_q, mont_b_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;

  logic [IW-1:0]    win;
  logic [IW-1:0]    cand_w;
  int unsigned      cand;

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    win    = last_q;
    cand   = 0;
    cand_w = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand   = (32'(last_q) + N_REQ - i) % N_REQ;
      cand_w = IW'(cand);
      if (i_req[cand_w]) win = cand_w;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    gnt_d    = '0;
    done_d   = '0;
    start_d  = 1'b0;
    result_d = result_q;
    mont_a_d = mont_a_q;
    mont_b_d = mont_b_q;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          idx_d      = win;
          last_d     = win;
          gnt_d[win] = 1'b1;
          start_d    = 1'b1;
          mont_a_d   = i_a[32'(win)*W +: W];
          mont_b_d   = i_b[32'(win)*W +: W];
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (i_mont_finish) begin
          result_d      = i_mont_result;
          done_d[idx_q] = 1'b1;
          state_d       = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      last_q   <= IW'(N_REQ - 1);
      idx_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      mont_a_q <= '0;
      mont_b_q <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      mont_a_q <= mont_a_d;
      mont_b_q <= mont_b_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_done       = done_q;
  assign o_result     = result_q;
  assign o_busy       = busy_q;
  assign o_mont_start = start_q;
  assign o_mont_a     = mont_a_q;
  assign o_mont_b     = mont_b_q;

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// Bench for rsa_mont_arbiter: stub multiplier, scoreboard of expected grants/products,
// and directed steps covering reset, contention, spurious finish and mid-job reset.
module tb_rsa_mont_arbiter;

  localparam int W  = 16;
  localparam int NR = 2;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [NR-1:0]   i_req;
  logic [NR*W-1:0] i_a, i_b;
  logic [NR-1:0]   o_gnt, o_done;
  logic [W-1:0]    o_result, o_mont_a, o_mont_b, i_mont_result;
  logic            o_busy, o_mont_start, i_mont_finish;

  logic            stub_fin, spur_fin, last_fin;
  int unsigned     stub_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int gnt_cnt  = 0;
  int done_cnt = 0;

  typedef struct {
    int unsigned  idx;
    logic [W-1:0] res;
  } exp_t;
  exp_t sb[$];

  rsa_mont_arbiter #(.W(W), .N_REQ(NR)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req         (i_req),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_gnt         (o_gnt),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_busy        (o_busy),
    .o_mont_start  (o_mont_start),
    .o_mont_a      (o_mont_a),
    .o_mont_b      (o_mont_b),
    .i_mont_result (i_mont_result),
    .i_mont_finish (i_mont_finish)
  );

  always #5 i_clk = ~i_clk;

  // Stub multiplier: finish strobe a fixed number of cycles after start, product of live operands.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stub_cnt <= 0;
      stub_fin <= 1'b0;
      last_fin <= 1'b0;
    end else begin
      last_fin <= stub_fin;
      stub_fin <= 1'b0;
      if (o_mont_start) begin
        stub_cnt <= 5;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) stub_fin <= 1'b1;
      end
    end
  end

  assign i_mont_result = o_mont_a * o_mont_b;
  assign i_mont_finish = stub_fin | spur_fin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (o_gnt != '0 || o_mont_start) begin
        gnt_cnt++;
        if (sb.size() == 0) chk("gnt_unexpected", 32'(o_gnt), 32'd0);
        else                chk("gnt_idx", 32'(o_gnt), 32'd1 << sb[0].idx);
        chk("gnt_start", 32'(o_mont_start), 32'(|o_gnt));
      end
      if (o_done != '0) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(o_done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_idx", 32'(o_done), 32'd1 << e.idx);
          chk("done_result", 32'(o_result), 32'(e.res));
          chk("done_after_finish", 32'(last_fin), 32'd1);
        end
      end
    end
  end

  task automatic post(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    i_a[k*W +: W] = a;
    i_b[k*W +: W] = b;
    i_req[k]      = 1'b1;
  endtask

  task automatic push(input int unsigned k, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.idx = k;
    e.res = a * b;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input int target);
    int n = 0;
    while (gnt_cnt < target && n < 200) begin
      @(negedge i_clk); #1;
      n++;
    end
    chk("wait_gnt", 32'(gnt_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge i_clk); #1;
      n++;
    end
    chk("wait_done", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(o_gnt), 32'd0);
    chk({tag, "_done"},   32'(o_done), 32'd0);
    chk({tag, "_result"}, 32'(o_result), 32'd0);
    chk({tag, "_busy"},   32'(o_busy), 32'd0);
    chk({tag, "_start"},  32'(o_mont_start), 32'd0);
    chk({tag, "_mont_a"}, 32'(o_mont_a), 32'd0);
    chk({tag, "_mont_b"}, 32'(o_mont_b), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    i_req    = '0;
    i_a      = '0;
    i_b      = '0;
    spur_fin = 1'b0;
    i_rst_n  = 1'b0;

    // Reset with random inputs.
    repeat (3) begin
      @(negedge i_clk);
      i_req    = NR'($urandom);
      i_a      = $urandom;
      i_b      = $urandom;
      spur_fin = 1'($urandom);
      #1 chk_all_zero("reset");
    end
    @(negedge i_clk);
    i_req    = '0;
    i_a      = '0;
    i_b      = '0;
    spur_fin = 1'b0;
    i_rst_n  = 1'b1;
    repeat (4) begin
      @(negedge i_clk); #1;
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_gnt", 32'(o_gnt), 32'd0);
    end

    // Single job from requester 1.
    @(negedge i_clk);
    post(1, 16'h0003, 16'h0007);
    push(1, 16'h0003, 16'h0007);
    @(posedge i_clk); #1;
    chk("single_gnt", 32'(o_gnt), 32'h2);
    chk("single_start", 32'(o_mont_start), 32'd1);
    i_req = '0;
    @(posedge i_clk); #1;
    chk("single_start_off", 32'(o_mont_start), 32'd0);
    chk("single_gnt_off", 32'(o_gnt), 32'd0);
    chk("single_busy", 32'(o_busy), 32'd1);
    wait_done(1);
    chk("single_result", 32'(o_result), 32'h0015);
    @(negedge i_clk); #1;
    chk("single_done_off", 32'(o_done), 32'd0);
    chk("single_idle", 32'(o_busy), 32'd0);
    repeat (3) @(negedge i_clk);
    chk("single_hold", 32'(o_result), 32'h0015);

    // Contention: both requesting continuously, grants alternate 0,1,0,1.
    base = gnt_cnt;
    @(negedge i_clk);
    post(0, 16'h0011, 16'h0003);
    post(1, 16'h0101, 16'h0002);
    push(0, 16'h0011, 16'h0003);
    push(1, 16'h0101, 16'h0002);
    push(0, 16'h0011, 16'h0003);
    push(1, 16'h0101, 16'h0002);
    wait_gnt(base + 4);
    i_req = '0;
    wait_done(done_cnt + (sb.size()));
    chk("contend_sb_empty", 32'(sb.size()), 32'd0);

    // Spurious finish in IDLE and in ISSUE.
    @(negedge i_clk);
    spur_fin = 1'b1;
    repeat (2) begin
      @(negedge i_clk); #1;
      chk("spur_idle_done", 32'(o_done), 32'd0);
      chk("spur_idle_busy", 32'(o_busy), 32'd0);
    end
    spur_fin = 1'b0;
    post(0, 16'h0004, 16'h0005);
    push(0, 16'h0004, 16'h0005);
    @(posedge i_clk); #1;
    i_req    = '0;
    spur_fin = 1'b1;
    @(posedge i_clk); #1;
    spur_fin = 1'b0;
    chk("spur_issue_done", 32'(o_done), 32'd0);
    chk("spur_issue_busy", 32'(o_busy), 32'd1);
    wait_done(done_cnt + 1);
    chk("spur_result", 32'(o_result), 32'd20);

    // Mid-job reset during WAIT.
    base = gnt_cnt;
    @(negedge i_clk);
    post(1, 16'h0005, 16'h0005);
    push(1, 16'h0005, 16'h0005);
    wait_gnt(base + 1);
    i_req = '0;
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    sb.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    post(0, 16'h0002, 16'h0009);
    post(1, 16'h0003, 16'h0003);
    push(0, 16'h0002, 16'h0009);
    @(posedge i_clk); #1;
    chk("midrst_first_gnt", 32'(o_gnt), 32'h1);
    i_req = '0;
    wait_done(done_cnt + 1);
    chk("midrst_result", 32'(o_result), 32'h0012);

    // Operand stability while in WAIT.
    @(negedge i_clk);
    post(1, 16'h1234, 16'h0100);
    push(1, 16'h1234, 16'h0100);
    @(posedge i_clk); #1;
    i_req = '0;
    i_a   = 32'hDEAD_BEEF;
    i_b   = 32'hCAFE_F00D;
    @(posedge i_clk); #1;
    chk("stable_a", 32'(o_mont_a), 32'h1234);
    chk("stable_b", 32'(o_mont_b), 32'h0100);
    repeat (2) @(negedge i_clk);
    chk("stable_a_late", 32'(o_mont_a), 32'h1234);
    wait_done(done_cnt + 1);
    chk("stable_result", 32'(o_result), 32'h3400);

    repeat (3) @(negedge i_clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
